// File: rtl/spi_xfer_ctrl_if.sv
// Bundle of command-side handshake and SPI pin signals for spi_xfer_ctrl.
// The slave modport is the controller's view; the master modport is the
// view of whoever drives commands and models the SPI device.
interface spi_xfer_ctrl_if #(
    parameter int SIZE = 40
) ();
    logic            start_in;
    logic [SIZE-1:0] data_in;
    logic [SIZE-1:0] data_out;
    logic            busy_out;
    logic            done_out;
    logic            sclk_out;
    logic            cs_n_out;
    logic            mosi_out;
    logic            miso_in;

    modport master (
        output start_in,
        output data_in,
        output miso_in,
        input  data_out,
        input  busy_out,
        input  done_out,
        input  sclk_out,
        input  cs_n_out,
        input  mosi_out
    );

    modport slave (
        input  start_in,
        input  data_in,
        input  miso_in,
        output data_out,
        output busy_out,
        output done_out,
        output sclk_out,
        output cs_n_out,
        output mosi_out
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-3 datagram controller: latches a TX word, frames it with chip
// select, shifts it out MSB first while capturing MISO, then reports the RX
// word with a one-cycle done pulse. Every pin and handshake output is a flop,
// so sclk_out and cs_n_out cannot glitch.
module spi_xfer_ctrl #(
    parameter int SIZE     = 40,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic               clk_in,
    input  logic               reset_n_in,
    spi_xfer_ctrl_if.slave     bus
);

    // One counter serves every phase; in SHIFT it spans one full SCLK period.
    localparam int SHIFT_LEN = 2 * CLK_DIV;
    localparam int MAX_A     = (CS_SETUP > SHIFT_LEN) ? CS_SETUP : SHIFT_LEN;
    localparam int MAX_B     = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int CNT_MAX   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX);
    localparam int BIT_W     = $clog2(SIZE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SIZE-1:0] tx_q, tx_d;
    logic [SIZE-1:0] rx_q, rx_d;
    logic [SIZE-1:0] data_out_q, data_out_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_out_d = data_out_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_in) begin
                    state_d   = ST_SETUP;
                    cnt_d     = {CNT_W{1'b0}};
                    bit_cnt_d = {BIT_W{1'b0}};
                    tx_d      = bus.data_in;
                    rx_d      = {SIZE{1'b0}};
                    cs_n_d    = 1'b0;
                    sclk_d    = 1'b1;
                    busy_d    = 1'b1;
                    mosi_d    = bus.data_in[SIZE-1];
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    // First SCLK falling edge; MSB is already on MOSI.
                    state_d   = ST_SHIFT;
                    cnt_d     = {CNT_W{1'b0}};
                    sclk_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SHIFT: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    // Rising SCLK: sample MISO, first bit ends up at the MSB.
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[SIZE-2:0], bus.miso_in};
                    cnt_d  = cnt_q + CNT_W'(1);
                end else if (cnt_q == CNT_W'(SHIFT_LEN - 1)) begin
                    if (bit_cnt_q == BIT_W'(SIZE - 1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        // Falling SCLK for the next bit: advance the shifter.
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        cnt_d     = {CNT_W{1'b0}};
                        sclk_d    = 1'b0;
                        tx_d      = {tx_q[SIZE-2:0], 1'b0};
                        mosi_d    = tx_q[SIZE-2];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                // After SIZE-1 shifts the shifter MSB is the original bit 0.
                mosi_d = tx_q[SIZE-1];
                if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                    state_d    = ST_GAP;
                    cnt_d      = {CNT_W{1'b0}};
                    cs_n_d     = 1'b1;
                    done_d     = 1'b1;
                    data_out_d = rx_q;
                    mosi_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == CNT_W'(CS_IDLE - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = {CNT_W{1'b0}};
                bit_cnt_d = {BIT_W{1'b0}};
                cs_n_d    = 1'b1;
                sclk_d    = 1'b1;
                mosi_d    = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State, counters, shift registers and registered outputs.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            bit_cnt_q  <= {BIT_W{1'b0}};
            tx_q       <= {SIZE{1'b0}};
            rx_q       <= {SIZE{1'b0}};
            data_out_q <= {SIZE{1'b0}};
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_out_q <= data_out_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.busy_out = busy_q;
    assign bus.done_out = done_q;
    assign bus.sclk_out = sclk_q;
    assign bus.cs_n_out = cs_n_q;
    assign bus.mosi_out = mosi_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: two instances (40-bit/CLK_DIV=2 and
// 8-bit/CLK_DIV=1), a cycle-indexed behavioural model compared every cycle,
// plus literal timing and data expectations.
module tb_spi_xfer_ctrl;

    localparam int A_S = 2, A_D = 2, A_N = 40, A_H = 2, A_G = 4;
    localparam int B_S = 2, B_D = 1, B_N = 8,  B_H = 2, B_G = 1;
    localparam int A_BUSY = A_S + 2*A_D*A_N + A_H + A_G;
    localparam int B_BUSY = B_S + 2*B_D*B_N + B_H + B_G;
    localparam int A_DONE = A_S + 2*A_D*A_N + A_H + 1;
    localparam int B_DONE = B_S + 2*B_D*B_N + B_H + 1;
    localparam int WAIT_MAX = 400;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    spi_xfer_ctrl_if #(.SIZE(A_N)) a_bus ();
    spi_xfer_ctrl_if #(.SIZE(B_N)) b_bus ();

    spi_xfer_ctrl #(.SIZE(A_N), .CLK_DIV(A_D), .CS_SETUP(A_S), .CS_HOLD(A_H), .CS_IDLE(A_G))
        dut_a (.clk_in(clk), .reset_n_in(rst_a), .bus(a_bus.slave));
    spi_xfer_ctrl #(.SIZE(B_N), .CLK_DIV(B_D), .CS_SETUP(B_S), .CS_HOLD(B_H), .CS_IDLE(B_G))
        dut_b (.clk_in(clk), .reset_n_in(rst_b), .bus(b_bus.slave));

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Expected {cs_n, sclk, mosi, busy, done} for cycle p after acceptance.
    function automatic logic [4:0] exp_pins(input int p, input int s, input int d, input int n,
                                            input int h, input logic [63:0] tx);
        int q, k, r;
        if (p == 0) return 5'b11000;
        if (p <= s) return {1'b0, 1'b1, tx[n-1], 1'b1, 1'b0};
        q = p - s - 1;
        if (q < 2*d*n) begin
            k = q / (2*d);
            r = q % (2*d);
            return {1'b0, (r >= d) ? 1'b1 : 1'b0, tx[n-1-k], 1'b1, 1'b0};
        end
        q = q - 2*d*n;
        if (q < h) return {1'b0, 1'b1, tx[0], 1'b1, 1'b0};
        q = q - h;
        return {1'b1, 1'b1, 1'b0, 1'b1, (q == 0) ? 1'b1 : 1'b0};
    endfunction

    // MISO source for instance A: loopback, or a mode-3 slave returning a_pat.
    logic        a_loop;
    logic [39:0] a_pat;
    logic        slave_bit = 1'b0;
    int          slave_idx = 0;
    always @(negedge a_bus.sclk_out or posedge a_bus.cs_n_out) begin
        if (a_bus.cs_n_out) slave_idx = 0;
        else if (slave_idx < A_N) begin
            slave_bit = a_pat[A_N-1-slave_idx];
            slave_idx++;
        end
    end
    assign a_bus.miso_in = a_loop ? a_bus.mosi_out : slave_bit;
    assign b_bus.miso_in = b_bus.mosi_out;

    // Behavioural model: cycle index since acceptance plus expected words.
    int          pa, pb;
    logic [39:0] txa, rxa_exp, douta_exp;
    logic [7:0]  txb, doutb_exp;

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            pa <= 0; txa <= '0; rxa_exp <= '0; douta_exp <= '0;
        end else if (pa == 0) begin
            if (a_bus.start_in) begin
                pa <= 1;
                txa <= a_bus.data_in;
                rxa_exp <= a_loop ? a_bus.data_in : a_pat;
            end
        end else begin
            if (pa + 1 == A_DONE) douta_exp <= rxa_exp;
            pa <= (pa == A_BUSY) ? 0 : pa + 1;
        end
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pb <= 0; txb <= '0; doutb_exp <= '0;
        end else if (pb == 0) begin
            if (b_bus.start_in) begin
                pb <= 1;
                txb <= b_bus.data_in;
            end
        end else begin
            if (pb + 1 == B_DONE) doutb_exp <= txb;
            pb <= (pb == B_BUSY) ? 0 : pb + 1;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("a_pins", 64'({a_bus.cs_n_out, a_bus.sclk_out, a_bus.mosi_out, a_bus.busy_out, a_bus.done_out}),
              64'(exp_pins(pa, A_S, A_D, A_N, A_H, 64'(txa))));
        check("a_data_out", 64'(a_bus.data_out), 64'(douta_exp));
        check("b_pins", 64'({b_bus.cs_n_out, b_bus.sclk_out, b_bus.mosi_out, b_bus.busy_out, b_bus.done_out}),
              64'(exp_pins(pb, B_S, B_D, B_N, B_H, 64'(txb))));
        check("b_data_out", 64'(b_bus.data_out), 64'(doutb_exp));
    end

    // Observation monitor: event positions relative to acceptance.
    int busy_cnt_a = 0, busy_cnt_b = 0, done_tot_a = 0, cs_fall_tot_a = 0;
    int cs_fall_p, first_fall_p, first_rise_p, last_rise_p, rise_cnt, done_p, cs_rise_p, mosi_bad;
    logic [39:0] mosi_seq;
    logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0;
    always @(negedge clk) begin
        if (a_bus.busy_out === 1'b1) busy_cnt_a++;
        if (b_bus.busy_out === 1'b1) busy_cnt_b++;
        if (a_bus.done_out === 1'b1) done_tot_a++;
        if (prev_cs && !a_bus.cs_n_out) cs_fall_tot_a++;
        if (pa == 1) begin
            cs_fall_p = -1; first_fall_p = -1; first_rise_p = -1; last_rise_p = -1;
            rise_cnt = 0; done_p = -1; cs_rise_p = -1; mosi_bad = 0; mosi_seq = '0;
        end
        if (pa != 0) begin
            if (!a_bus.cs_n_out && cs_fall_p < 0) cs_fall_p = pa;
            if (prev_sclk && !a_bus.sclk_out && first_fall_p < 0) first_fall_p = pa;
            if (!prev_sclk && a_bus.sclk_out) begin
                if (first_rise_p < 0) first_rise_p = pa;
                last_rise_p = pa;
                rise_cnt++;
                if (a_bus.mosi_out != prev_mosi) mosi_bad++;
                mosi_seq = {mosi_seq[38:0], a_bus.mosi_out};
            end
            if (a_bus.done_out) done_p = pa;
            if (!prev_cs && a_bus.cs_n_out && cs_rise_p < 0) cs_rise_p = pa;
        end
        prev_cs = a_bus.cs_n_out;
        prev_sclk = a_bus.sclk_out;
        prev_mosi = a_bus.mosi_out;
    end

    task automatic start_a(input logic [39:0] d);
        a_bus.data_in = d;
        a_bus.start_in = 1'b1;
        @(negedge clk);
        a_bus.start_in = 1'b0;
    endtask

    task automatic start_b(input logic [7:0] d);
        b_bus.data_in = d;
        b_bus.start_in = 1'b1;
        @(negedge clk);
        b_bus.start_in = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        int t = 0;
        while (((sel ? b_bus.busy_out : a_bus.busy_out) === 1'b1) && t < WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        check(sel ? "b_idle_timeout" : "a_idle_timeout", 64'(t < WAIT_MAX), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] d, d2;
        logic [7:0]  db;
        int d0, c0, t;
        a_bus.start_in = 1'b0; a_bus.data_in = '0;
        b_bus.start_in = 1'b0; b_bus.data_in = '0;
        a_loop = 1'b1; a_pat = '0;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pins_a", 64'({a_bus.cs_n_out, a_bus.sclk_out, a_bus.mosi_out, a_bus.busy_out, a_bus.done_out}), 64'(5'b11000));
        check("reset_data_a", 64'(a_bus.data_out), 64'(0));
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback with timing landmarks.
        busy_cnt_a = 0; d0 = done_tot_a;
        start_a(40'hA5_1234_5678);
        wait_idle(1'b0);
        repeat (2) @(negedge clk);
        check("t1_busy_len", 64'(busy_cnt_a), 64'(168));
        check("t1_done_cycle", 64'(done_p), 64'(165));
        check("t1_done_count", 64'(done_tot_a - d0), 64'(1));
        check("t1_data_out", 64'(a_bus.data_out), 64'(40'hA5_1234_5678));
        check("t1_cs_fall", 64'(cs_fall_p), 64'(1));
        check("t1_first_fall", 64'(first_fall_p), 64'(3));
        check("t1_first_rise", 64'(first_rise_p), 64'(5));
        check("t1_last_rise", 64'(last_rise_p), 64'(161));
        check("t1_cs_rise", 64'(cs_rise_p), 64'(165));
        check("t1_rise_count", 64'(rise_cnt), 64'(40));
        check("t1_mosi_stable", 64'(mosi_bad), 64'(0));

        // Fixed MISO pattern from the slave model.
        a_loop = 1'b0; a_pat = 40'h0F_FFFF_0000;
        d = {8'($urandom()), $urandom()};
        start_a(d);
        wait_idle(1'b0);
        repeat (2) @(negedge clk);
        check("t2_data_out", 64'(a_bus.data_out), 64'(40'h0F_FFFF_0000));
        check("t2_mosi_seq", 64'(mosi_seq), 64'(d));
        a_loop = 1'b1;

        // Start while busy is ignored; data_in change after accept is harmless.
        c0 = cs_fall_tot_a;
        d = {8'($urandom()), $urandom()};
        start_a(d);
        repeat (9) @(negedge clk);
        a_bus.data_in = '0;
        repeat (40) @(negedge clk);
        a_bus.start_in = 1'b1;
        @(negedge clk);
        a_bus.start_in = 1'b0;
        wait_idle(1'b0);
        repeat (4) @(negedge clk);
        check("t3_one_transfer", 64'(cs_fall_tot_a - c0), 64'(1));
        check("t3_mosi_seq", 64'(mosi_seq), 64'(d));
        check("t3_data_out", 64'(a_bus.data_out), 64'(d));

        // start_in held high re-triggers one cycle after busy drops.
        d = {8'($urandom()), $urandom()};
        a_bus.data_in = d;
        a_bus.start_in = 1'b1;
        @(negedge clk);
        wait_idle(1'b0);
        t = 0;
        while (a_bus.cs_n_out === 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        a_bus.start_in = 1'b0;
        check("t4_restart_gap", 64'(t), 64'(1));
        wait_idle(1'b0);
        repeat (2) @(negedge clk);
        check("t4_data_out", 64'(a_bus.data_out), 64'(d));

        // Asynchronous reset mid-SHIFT.
        d0 = done_tot_a;
        d = {8'($urandom()), $urandom()};
        start_a(d);
        repeat (79) @(negedge clk);
        #1 rst_a = 1'b0;
        #1;
        check("t5_reset_pins", 64'({a_bus.cs_n_out, a_bus.sclk_out, a_bus.busy_out}), 64'(3'b110));
        check("t5_reset_data", 64'(a_bus.data_out), 64'(0));
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_no_done", 64'(done_tot_a - d0), 64'(0));
        d2 = {8'($urandom()), $urandom()};
        start_a(d2);
        wait_idle(1'b0);
        repeat (2) @(negedge clk);
        check("t5_after_reset", 64'(a_bus.data_out), 64'(d2));

        // Small instance: CLK_DIV=1, SIZE=8, CS_IDLE=1.
        busy_cnt_b = 0;
        start_b(8'h81);
        wait_idle(1'b1);
        repeat (2) @(negedge clk);
        check("t6_busy_len", 64'(busy_cnt_b), 64'(21));
        check("t6_data_out", 64'(b_bus.data_out), 64'(8'h81));

        // Randomised transfers on both instances.
        for (int i = 0; i < 4; i++) begin
            a_loop = 1'($urandom_range(0, 1));
            a_pat = {8'($urandom()), $urandom()};
            d = {8'($urandom()), $urandom()};
            start_a(d);
            wait_idle(1'b0);
            repeat (2) @(negedge clk);
            check("rand_a_data_out", 64'(a_bus.data_out), 64'(a_loop ? d : a_pat));
        end
        a_loop = 1'b1;
        for (int i = 0; i < 6; i++) begin
            db = 8'($urandom());
            start_b(db);
            wait_idle(1'b1);
            @(negedge clk);
            check("rand_b_data_out", 64'(b_bus.data_out), 64'(db));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
